// File: rtl/rv_mem_pkg.sv
// Shared types and default widths for the instruction/data memory arbiter.
package rv_mem_pkg;

  localparam int unsigned DefAddrW     = 32;
  localparam int unsigned DefDataW     = 32;
  localparam int unsigned DefMemLat    = 1;
  localparam int unsigned DefStarveMax = 4;

  // Counter widths cover the legal parameter ranges (MEM_LAT 1..7, STARVE_MAX 1..15)
  localparam int unsigned LatCntW    = 3;
  localparam int unsigned StarveCntW = 4;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    OWN_IF = 2'd1,
    OWN_LS = 2'd2
  } arb_owner_t;

endpackage

// File: rtl/rv_mem_arbiter.sv
// Arbitrates a single-port word memory between the instruction-fetch (IF) and
// load/store (LS) ports. LS has priority, but IF is forced through once it has
// been denied STARVE_MAX consecutive grantable cycles. One read may be
// outstanding; its data is routed back to whichever port issued it.
module rv_mem_arbiter
  import rv_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = DefAddrW,
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned MEM_LAT    = DefMemLat,
  parameter int unsigned STARVE_MAX = DefStarveMax
) (
  input  logic                i_clk,
  input  logic                i_rst,
  // Instruction-fetch port
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  output logic                o_if_gnt,
  output logic                o_if_rvalid,
  output logic [DATA_W-1:0]   o_if_rdata,
  // Load/store port
  input  logic                i_ls_req,
  input  logic                i_ls_we,
  input  logic [DATA_W/8-1:0] i_ls_be,
  input  logic [ADDR_W-1:0]   i_ls_addr,
  input  logic [DATA_W-1:0]   i_ls_wdata,
  output logic                o_ls_gnt,
  output logic                o_ls_rvalid,
  output logic [DATA_W-1:0]   o_ls_rdata,
  // Memory port
  output logic                o_mem_en,
  output logic                o_mem_we,
  output logic [DATA_W/8-1:0] o_mem_be,
  output logic [ADDR_W-3:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic                o_busy
);

  localparam logic [LatCntW-1:0]    LatLast   = LatCntW'(MEM_LAT);
  localparam logic [StarveCntW-1:0] StarveTop = StarveCntW'(STARVE_MAX);

  arb_state_t              r_state, w_state_nxt;
  arb_owner_t              r_owner, w_owner_nxt;
  logic [LatCntW-1:0]      r_lat_cnt, w_lat_cnt_nxt;
  logic [StarveCntW-1:0]   r_starve_cnt, w_starve_cnt_nxt;

  logic w_resp;
  logic w_grantable;
  logic w_if_force;
  logic w_ls_gnt;
  logic w_if_gnt;
  logic w_read_gnt;
  logic w_unused_addr_lsbs;

  // Byte-offset bits are ignored: the memory is word addressed
  assign w_unused_addr_lsbs = ^{i_if_addr[1:0], i_ls_addr[1:0]};

  // Response cycle: last cycle of WAIT, doubles as a grant slot
  assign w_resp      = (r_state == WAIT) && (r_lat_cnt == LatLast);
  assign w_grantable = !i_rst && ((r_state == IDLE) || w_resp);
  assign w_if_force  = i_if_req && (r_starve_cnt == StarveTop);
  assign w_ls_gnt    = w_grantable && i_ls_req && !w_if_force;
  assign w_if_gnt    = w_grantable && i_if_req && !w_ls_gnt;
  assign w_read_gnt  = w_if_gnt || (w_ls_gnt && !i_ls_we);

  assign o_if_gnt = w_if_gnt;
  assign o_ls_gnt = w_ls_gnt;
  assign o_busy   = !i_rst && (r_state == WAIT);

  // State, owner and counter registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_owner      <= NONE;
      r_lat_cnt    <= '0;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_lat_cnt    <= w_lat_cnt_nxt;
      r_starve_cnt <= w_starve_cnt_nxt;
    end
  end

  // Next state: a read grant (also legal in the response cycle) re-enters WAIT
  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_lat_cnt_nxt = r_lat_cnt;
    unique case (r_state)
      IDLE: ;
      WAIT: begin
        if (w_resp) begin
          w_state_nxt   = IDLE;
          w_owner_nxt   = NONE;
          w_lat_cnt_nxt = '0;
        end else begin
          w_lat_cnt_nxt = r_lat_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt   = IDLE;
        w_owner_nxt   = NONE;
        w_lat_cnt_nxt = '0;
      end
    endcase
    if (w_read_gnt) begin
      w_state_nxt   = WAIT;
      w_lat_cnt_nxt = LatCntW'(1);
      w_owner_nxt   = w_if_gnt ? OWN_IF : OWN_LS;
    end
  end

  // Starvation counter: counts denied grantable IF cycles, holds while in WAIT
  always_comb begin
    w_starve_cnt_nxt = r_starve_cnt;
    if (!i_if_req || w_if_gnt) begin
      w_starve_cnt_nxt = '0;
    end else if (w_grantable && (r_starve_cnt != StarveTop)) begin
      w_starve_cnt_nxt = r_starve_cnt + 1'b1;
    end
  end

  // Memory command from whichever port won this cycle
  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_be    = '0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (w_ls_gnt) begin
      o_mem_en    = 1'b1;
      o_mem_we    = i_ls_we;
      o_mem_be    = i_ls_we ? i_ls_be : '1;
      o_mem_addr  = i_ls_addr[ADDR_W-1:2];
      o_mem_wdata = i_ls_we ? i_ls_wdata : '0;
    end else if (w_if_gnt) begin
      o_mem_en   = 1'b1;
      o_mem_be   = '1;
      o_mem_addr = i_if_addr[ADDR_W-1:2];
    end
  end

  // Read-data routing: only the owner sees rvalid, the other port reads zero
  always_comb begin
    o_if_rvalid = !i_rst && w_resp && (r_owner == OWN_IF);
    o_ls_rvalid = !i_rst && w_resp && (r_owner == OWN_LS);
    o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
    o_ls_rdata  = o_ls_rvalid ? i_mem_rdata : '0;
  end

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Self-checking bench: two arbiter instances (MEM_LAT=1/STARVE_MAX=4 and
// MEM_LAT=3/STARVE_MAX=2) run directed and random traffic against a
// timestamp-based reference model and behavioural memories.
module tb_rv_mem_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned LAT0 = 1;
  localparam int unsigned LAT1 = 3;
  localparam int unsigned SM0  = 4;
  localparam int unsigned SM1  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]         if_req, if_gnt, if_rvalid;
  logic [1:0][31:0]   if_addr, if_rdata;
  logic [1:0]         ls_req, ls_we, ls_gnt, ls_rvalid;
  logic [1:0][3:0]    ls_be, mem_be;
  logic [1:0][31:0]   ls_addr, ls_wdata, ls_rdata;
  logic [1:0]         mem_en, mem_we, busy;
  logic [1:0][29:0]   mem_addr;
  logic [1:0][31:0]   mem_wdata, mem_rdata;

  rv_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT0), .STARVE_MAX(SM0)) u_dut0 (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req[0]), .i_if_addr(if_addr[0]), .o_if_gnt(if_gnt[0]),
    .o_if_rvalid(if_rvalid[0]), .o_if_rdata(if_rdata[0]),
    .i_ls_req(ls_req[0]), .i_ls_we(ls_we[0]), .i_ls_be(ls_be[0]), .i_ls_addr(ls_addr[0]),
    .i_ls_wdata(ls_wdata[0]), .o_ls_gnt(ls_gnt[0]), .o_ls_rvalid(ls_rvalid[0]),
    .o_ls_rdata(ls_rdata[0]),
    .o_mem_en(mem_en[0]), .o_mem_we(mem_we[0]), .o_mem_be(mem_be[0]),
    .o_mem_addr(mem_addr[0]), .o_mem_wdata(mem_wdata[0]), .i_mem_rdata(mem_rdata[0]),
    .o_busy(busy[0])
  );

  rv_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT1), .STARVE_MAX(SM1)) u_dut1 (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req[1]), .i_if_addr(if_addr[1]), .o_if_gnt(if_gnt[1]),
    .o_if_rvalid(if_rvalid[1]), .o_if_rdata(if_rdata[1]),
    .i_ls_req(ls_req[1]), .i_ls_we(ls_we[1]), .i_ls_be(ls_be[1]), .i_ls_addr(ls_addr[1]),
    .i_ls_wdata(ls_wdata[1]), .o_ls_gnt(ls_gnt[1]), .o_ls_rvalid(ls_rvalid[1]),
    .o_ls_rdata(ls_rdata[1]),
    .o_mem_en(mem_en[1]), .o_mem_we(mem_we[1]), .o_mem_be(mem_be[1]),
    .o_mem_addr(mem_addr[1]), .o_mem_wdata(mem_wdata[1]), .i_mem_rdata(mem_rdata[1]),
    .o_busy(busy[1])
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int mode  = 2;  // 0 random, 1 LS store flood + IF waiting, 2 hold-until-granted

  // Reference model: memory free from ready_cyc; pending read answers at resp_cyc
  int          ready_cyc [2];
  int          resp_cyc  [2];
  bit          resp_pend [2];
  int          resp_own  [2];  // 1 IF, 2 LS
  logic [31:0] resp_data [2];
  int          starve    [2];
  logic [31:0] ref_mem   [2][16];
  bit          last_if_g [2];
  bit          last_ls_g [2];
  // Behavioural RAM driven by the DUT memory port
  logic [31:0] env_mem   [2][16];
  int          env_cyc   [2];
  logic [31:0] env_data  [2];

  function automatic int lat_of(input int k);
    return (k == 0) ? int'(LAT0) : int'(LAT1);
  endfunction

  function automatic int smax_of(input int k);
    return (k == 0) ? int'(SM0) : int'(SM1);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input int k, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s[dut%0d] cyc=%0d observed=%0h expected=%0h", tag, k, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ready_cyc[k] = -1;
      resp_pend[k] = 1'b0;
      resp_own[k]  = 0;
      starve[k]    = 0;
      last_if_g[k] = 1'b0;
      last_ls_g[k] = 1'b0;
      env_cyc[k]   = -1;
    end
  endtask

  task automatic chk_quiet(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_if_gnt"}, k, if_gnt[k], 0);
      chk({tag, "_ls_gnt"}, k, ls_gnt[k], 0);
      chk({tag, "_if_rvalid"}, k, if_rvalid[k], 0);
      chk({tag, "_ls_rvalid"}, k, ls_rvalid[k], 0);
      chk({tag, "_if_rdata"}, k, if_rdata[k], 0);
      chk({tag, "_ls_rdata"}, k, ls_rdata[k], 0);
      chk({tag, "_mem_en"}, k, mem_en[k], 0);
      chk({tag, "_busy"}, k, busy[k], 0);
    end
  endtask

  task automatic new_stim();
    for (int k = 0; k < 2; k++) begin
      if (mode == 0) begin
        if (!if_req[k] || last_if_g[k]) begin
          if_req[k]  = ($urandom_range(0, 2) != 0);
          if_addr[k] = $urandom();
        end else if ($urandom_range(0, 15) == 0) begin
          if_req[k] = 1'b0;
        end
        if (!ls_req[k] || last_ls_g[k]) begin
          ls_req[k]   = ($urandom_range(0, 2) != 0);
          ls_we[k]    = 1'($urandom_range(0, 1));
          ls_be[k]    = 4'($urandom());
          ls_addr[k]  = $urandom();
          ls_wdata[k] = $urandom();
        end else if ($urandom_range(0, 15) == 0) begin
          ls_req[k] = 1'b0;
        end
      end else if (mode == 1) begin
        if_req[k] = 1'b1;
        if (last_if_g[k]) if_addr[k] = $urandom();
        ls_req[k] = 1'b1;
        ls_we[k]  = 1'b1;
        if (last_ls_g[k]) begin
          ls_be[k]    = 4'($urandom());
          ls_addr[k]  = $urandom();
          ls_wdata[k] = $urandom();
        end
      end else begin
        if (last_if_g[k]) if_req[k] = 1'b0;
        if (last_ls_g[k]) ls_req[k] = 1'b0;
      end
    end
  endtask

  // One clock cycle: entered at posedge+1 with inputs settled, leaves at next posedge+1
  task automatic step();
    for (int k = 0; k < 2; k++)
      mem_rdata[k] = (cyc == env_cyc[k]) ? env_data[k] : $urandom();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      int lat;
      int smax;
      int win;
      bit resp;
      bit grantable;
      bit store;
      bit rd;
      lat       = lat_of(k);
      smax      = smax_of(k);
      resp      = resp_pend[k] && (cyc == resp_cyc[k]);
      grantable = (cyc >= ready_cyc[k]);
      win       = 0;
      if (grantable) begin
        if (ls_req[k] && !(if_req[k] && starve[k] >= smax)) win = 2;
        else if (if_req[k]) win = 1;
      end
      store = (win == 2) && ls_we[k];
      rd    = (win != 0) && !store;

      chk("if_gnt", k, if_gnt[k], win == 1);
      chk("ls_gnt", k, ls_gnt[k], win == 2);
      chk("if_rvalid", k, if_rvalid[k], resp && resp_own[k] == 1);
      chk("ls_rvalid", k, ls_rvalid[k], resp && resp_own[k] == 2);
      chk("if_rdata", k, if_rdata[k], (resp && resp_own[k] == 1) ? resp_data[k] : 32'h0);
      chk("ls_rdata", k, ls_rdata[k], (resp && resp_own[k] == 2) ? resp_data[k] : 32'h0);
      chk("busy", k, busy[k], resp_pend[k] && cyc <= resp_cyc[k]);
      chk("mem_en", k, mem_en[k], win != 0);
      if (win != 0) begin
        chk("mem_we", k, mem_we[k], store);
        chk("mem_addr", k, mem_addr[k], (win == 2) ? ls_addr[k][31:2] : if_addr[k][31:2]);
        chk("mem_be", k, mem_be[k], store ? ls_be[k] : 4'hf);
        if (store) chk("mem_wdata", k, mem_wdata[k], ls_wdata[k]);
      end

      if (mem_en[k]) begin
        if (mem_we[k]) begin
          env_mem[k][mem_addr[k][3:0]] = merge(env_mem[k][mem_addr[k][3:0]], mem_wdata[k],
                                               mem_be[k]);
        end else begin
          env_cyc[k]  = cyc + lat;
          env_data[k] = env_mem[k][mem_addr[k][3:0]];
        end
      end

      if (resp) resp_pend[k] = 1'b0;
      if (rd) begin
        resp_pend[k] = 1'b1;
        resp_cyc[k]  = cyc + lat;
        ready_cyc[k] = cyc + lat;
        resp_own[k]  = win;
        resp_data[k] = (win == 2) ? ref_mem[k][ls_addr[k][5:2]] : ref_mem[k][if_addr[k][5:2]];
      end
      if (store)
        ref_mem[k][ls_addr[k][5:2]] = merge(ref_mem[k][ls_addr[k][5:2]], ls_wdata[k], ls_be[k]);
      if (!if_req[k] || win == 1) starve[k] = 0;
      else if (grantable && starve[k] < smax) starve[k] = starve[k] + 1;
      last_if_g[k] = (win == 1);
      last_ls_g[k] = (win == 2);
    end
    @(posedge clk);
    #1;
    cyc++;
    new_stim();
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if_req[k]    = 1'b1;
      if_addr[k]   = 32'h8;
      ls_req[k]    = 1'b1;
      ls_we[k]     = 1'b0;
      ls_be[k]     = 4'hf;
      ls_addr[k]   = 32'h10;
      ls_wdata[k]  = 32'h0;
      mem_rdata[k] = 32'hFFFF_FFFF;
      for (int w = 0; w < 16; w++) begin
        ref_mem[k][w] = $urandom();
        env_mem[k][w] = ref_mem[k][w];
      end
    end
    model_reset();
    #1;
    chk_quiet("rst_hold");
    repeat (2) @(posedge clk);
    #1;
    chk_quiet("rst_hold2");
    if_req = '0;
    ls_req = '0;
    rst    = 1'b0;
    step();

    // IF read of byte 0x8 alone
    for (int k = 0; k < 2; k++) begin
      if_req[k]  = 1'b1;
      if_addr[k] = 32'h8;
    end
    repeat (5) step();

    // IF and LS load collide; LS first, IF in the response cycle
    for (int k = 0; k < 2; k++) begin
      if_req[k]  = 1'b1;
      if_addr[k] = 32'hC;
      ls_req[k]  = 1'b1;
      ls_we[k]   = 1'b0;
      ls_addr[k] = 32'h10;
    end
    repeat (10) step();

    // Partial store to word 1, then read it back through IF
    for (int k = 0; k < 2; k++) begin
      ls_req[k]   = 1'b1;
      ls_we[k]    = 1'b1;
      ls_be[k]    = 4'b0011;
      ls_addr[k]  = 32'h4;
      ls_wdata[k] = 32'hAABB_CCDD;
    end
    repeat (3) step();
    for (int k = 0; k < 2; k++) begin
      if_req[k]  = 1'b1;
      if_addr[k] = 32'h4;
    end
    repeat (5) step();

    // Zero byte-enable store is still granted
    for (int k = 0; k < 2; k++) begin
      ls_req[k]   = 1'b1;
      ls_we[k]    = 1'b1;
      ls_be[k]    = 4'b0000;
      ls_addr[k]  = 32'h4;
      ls_wdata[k] = 32'h1234_5678;
    end
    repeat (3) step();

    // Continuous LS stores against a waiting IF
    mode = 1;
    repeat (30) step();
    mode = 0;
    repeat (300) step();

    // Reset while a read is outstanding
    mode = 2;
    if_req = '0;
    ls_req = '0;
    repeat (6) step();
    for (int k = 0; k < 2; k++) begin
      if_req[k]  = 1'b1;
      if_addr[k] = $urandom();
    end
    step();
    for (int k = 0; k < 2; k++) begin
      ls_req[k]  = 1'b1;
      ls_we[k]   = 1'b0;
      ls_addr[k] = $urandom();
    end
    rst = 1'b1;
    #1;
    chk_quiet("rst_wait");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    repeat (6) step();

    mode = 0;
    repeat (300) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
